// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle requests into a HOLD_CYCLES-long level followed by a GAP_CYCLES lockout.
// Optional macro PULSE_STRETCHER_RETRIGGER_EN lets a request during the hold restart it instead of being dropped.
module pulse_stretcher #(
  parameter logic [15:0] HOLD_CYCLES = 16'd1000,
  parameter logic [7:0]  GAP_CYCLES  = 8'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulso,
  output logic       nivel,
  output logic       busy,
  output logic       done,
  output logic [7:0] dropped
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam logic [15:0] HOLD_LOAD = HOLD_CYCLES - 16'd1;
  localparam logic [15:0] GAP_LOAD  = {8'd0, GAP_CYCLES} - 16'd1;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam logic RETRIG = 1'b1;
`else
  localparam logic RETRIG = 1'b0;
`endif

  state_t      state;
  logic [15:0] cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      nivel   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dropped <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pulso) begin
            state <= HOLD;
            cnt   <= HOLD_LOAD;
            nivel <= 1'b1;
            busy  <= 1'b1;
          end
        end
        HOLD: begin
          // A retrigger reload takes precedence over the end-of-hold transition.
          if (pulso && RETRIG) begin
            cnt <= HOLD_LOAD;
          end else begin
            if (pulso) dropped <= sat_inc(dropped);
            if (cnt == 16'd0) begin
              nivel <= 1'b0;
              done  <= 1'b1;
              if (GAP_CYCLES == 8'd0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= GAP;
                cnt   <= GAP_LOAD;
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
        end
        GAP: begin
          if (pulso) dropped <= sat_inc(dropped);
          if (cnt == 16'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= 16'd0;
          nivel   <= 1'b0;
          busy    <= 1'b0;
          dropped <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: two instances (gap of 2 and gap of 0, hold of 4) driven by shared
// directed and random stimulus, compared each cycle against a remaining-cycles reference model.
module tb_pulse_stretcher;

  localparam int HOLD = 4;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pulso = 1'b0;
  logic       nivel_a, busy_a, done_a;
  logic [7:0] dropped_a;
  logic       nivel_b, busy_b, done_b;
  logic [7:0] dropped_b;

  int checks = 0;
  int errors = 0;

  // Model: h = nivel-high cycles left including this one, g = gap cycles left.
  int h [2];
  int g [2];
  int dn[2];
  int dr[2];

  always #5 clk = ~clk;

  pulse_stretcher #(.HOLD_CYCLES(16'd4), .GAP_CYCLES(8'd2)) dut_a (
    .clk(clk), .reset(reset), .pulso(pulso),
    .nivel(nivel_a), .busy(busy_a), .done(done_a), .dropped(dropped_a)
  );

  pulse_stretcher #(.HOLD_CYCLES(16'd4), .GAP_CYCLES(8'd0)) dut_b (
    .clk(clk), .reset(reset), .pulso(pulso),
    .nivel(nivel_b), .busy(busy_b), .done(done_b), .dropped(dropped_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int gap, input bit p, input bit r);
    if (!r) begin
      h[k] = 0; g[k] = 0; dn[k] = 0; dr[k] = 0;
      return;
    end
    dn[k] = 0;
    if (h[k] > 0) begin
      if (p && RETRIG) begin
        h[k] = HOLD;
      end else begin
        if (p && dr[k] < 255) dr[k]++;
        h[k]--;
        if (h[k] == 0) begin
          dn[k] = 1;
          g[k] = gap;
        end
      end
    end else if (g[k] > 0) begin
      if (p && dr[k] < 255) dr[k]++;
      g[k]--;
    end else if (p) begin
      h[k] = HOLD;
    end
  endtask

  task automatic cyc(input bit p, input bit r);
    pulso = p;
    reset = r;
    @(posedge clk);
    #1;
    model_step(0, GAP_A, p, r);
    model_step(1, GAP_B, p, r);
    chk("a_nivel",   int'(nivel_a),   int'(h[0] > 0));
    chk("a_busy",    int'(busy_a),    int'(h[0] > 0 || g[0] > 0));
    chk("a_done",    int'(done_a),    dn[0]);
    chk("a_dropped", int'(dropped_a), dr[0]);
    chk("b_nivel",   int'(nivel_b),   int'(h[1] > 0));
    chk("b_busy",    int'(busy_b),    int'(h[1] > 0 || g[1] > 0));
    chk("b_done",    int'(done_b),    dn[1]);
    chk("b_dropped", int'(dropped_b), dr[1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
  endtask

  initial begin
    int high_cnt;
    int done_cnt;
    for (int k = 0; k < 2; k++) begin
      h[k] = 0; g[k] = 0; dn[k] = 0; dr[k] = 0;
    end

    // Reset state
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk("rst_nivel", int'(nivel_a), 0);
    chk("rst_dropped", int'(dropped_a), 0);
    idle(2);

    // Single pulse: exactly HOLD cycles of nivel
    high_cnt = 0;
    cyc(1'b1, 1'b1);
    if (nivel_a) high_cnt++;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1);
      if (nivel_a) high_cnt++;
    end
    chk("single_hold_len", high_cnt, HOLD);

    // Pulses at cycles 0 and 2 (retrigger or drop)
    cyc(1'b1, 1'b1); cyc(1'b0, 1'b1); cyc(1'b1, 1'b1);
    idle(10);

    // Pulse at 0, pulse in last GAP cycle (6), pulse at 7
    cyc(1'b1, 1'b1);
    idle(5);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    idle(10);

    // Gap-less back-to-back: pulses at 0 and 5
    cyc(1'b1, 1'b1);
    idle(4);
    cyc(1'b1, 1'b1);
    idle(8);

    // Reset mid-hold: no done from the aborted hold
    done_cnt = 0;
    cyc(1'b1, 1'b1); done_cnt += int'(done_a);
    cyc(1'b0, 1'b1); done_cnt += int'(done_a);
    cyc(1'b0, 1'b0); done_cnt += int'(done_a);
    chk("abort_nivel", int'(nivel_a), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1);
      done_cnt += int'(done_a);
    end
    chk("abort_no_done", done_cnt, 0);
    cyc(1'b1, 1'b1);
    idle(8);

    // Continuous request: saturation of dropped when no retrigger
    for (int i = 0; i < 400; i++) cyc(1'b1, 1'b1);
    if (!RETRIG) chk("sat_255", int'(dropped_a), 255);
    idle(4);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1);
    if (!RETRIG) chk("sat_stays", int'(dropped_a), 255);
    idle(10);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit p;
      bit r;
      p = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) >= 2);
      cyc(p, r);
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
